// File: rtl/fp_normalizer_pkg.sv
// Shared widths, saturation constants and FSM encoding for the fixed-point to
// 8-bit float normalizer (1 sign, 3 exponent, 4 significand bits).
package fp_normalizer_pkg;

    localparam int MAG_W = 12;
    localparam int EXP_W = 3;
    localparam int SIG_W = 4;

    localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
    localparam logic [SIG_W-1:0] SIG_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_normalizer_if.sv
// Upstream/downstream handshake bundle of the normalizer plus its FSM state for observation.
interface fp_normalizer_if;
    import fp_normalizer_pkg::*;

    // Both sides: a transfer happens on a rising edge where valid && ready; the
    // producer holds its payload stable while valid is high and ready is low.
    logic             in_valid;
    logic             in_ready;
    logic             sign;
    logic [MAG_W-1:0] magnitude;
    logic             out_valid;
    logic             out_ready;
    logic             fp_sign;
    logic [EXP_W-1:0] fp_exp;
    logic [SIG_W-1:0] fp_sig;
    state_t           dbg_state;

    modport slave (
        input  in_valid, sign, magnitude, out_ready,
        output in_ready, out_valid, fp_sign, fp_exp, fp_sig, dbg_state
    );

    modport master (
        output in_valid, sign, magnitude, out_ready,
        input  in_ready, out_valid, fp_sign, fp_exp, fp_sig, dbg_state
    );

endinterface

// File: rtl/fp_round.sv
// Combinational rounding of a normalized magnitude: round-half-up on the bit
// after the significand, with carry into the exponent and saturation.
module fp_round
    import fp_normalizer_pkg::*;
(
    input  logic [MAG_W-1:0] w,
    input  logic [EXP_W-1:0] e,
    output logic [EXP_W-1:0] exp,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_raw;
    logic             rbit;
    logic             unused_low;

    assign sig_raw    = w[10:7];
    assign rbit       = w[6];
    assign unused_low = ^w[5:0];

    always_comb begin
        exp = e;
        sig = sig_raw;
        if (w[11]) begin
            // Magnitude 2048 does not fit the format at all.
            exp = EXP_MAX;
            sig = SIG_MAX;
        end else if (rbit) begin
            if (sig_raw != SIG_MAX) begin
                sig = sig_raw + 4'd1;
            end else if (e != EXP_MAX) begin
                exp = e + 3'd1;
                sig = 4'b1000;
            end else begin
                exp = EXP_MAX;
                sig = SIG_MAX;
            end
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Normalizes a 12-bit magnitude by one left shift per clock until the leading
// one reaches bit 10 (or the exponent bottoms out), then rounds and holds the result.
module fp_normalizer
    import fp_normalizer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fp_normalizer_if.slave  bus
);

    state_t           state_q, state_d;
    logic [MAG_W-1:0] w_q, w_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic             s_q, s_d;
    logic             fp_sign_q, fp_sign_d;
    logic [EXP_W-1:0] fp_exp_q, fp_exp_d;
    logic [SIG_W-1:0] fp_sig_q, fp_sig_d;
    logic [EXP_W-1:0] rnd_exp;
    logic [SIG_W-1:0] rnd_sig;

    fp_round u_round (
        .w   (w_q),
        .e   (e_q),
        .exp (rnd_exp),
        .sig (rnd_sig)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            w_q       <= '0;
            e_q       <= '0;
            s_q       <= 1'b0;
            fp_sign_q <= 1'b0;
            fp_exp_q  <= '0;
            fp_sig_q  <= '0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            e_q       <= e_d;
            s_q       <= s_d;
            fp_sign_q <= fp_sign_d;
            fp_exp_q  <= fp_exp_d;
            fp_sig_q  <= fp_sig_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        e_d       = e_q;
        s_d       = s_q;
        fp_sign_d = fp_sign_q;
        fp_exp_d  = fp_exp_q;
        fp_sig_d  = fp_sig_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_d     = bus.magnitude;
                    s_d     = bus.sign;
                    e_d     = EXP_MAX;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Exponent 0 stops shifting: small values keep their low bits unscaled.
                if (w_q[11] || w_q[10] || (e_q == '0)) begin
                    state_d = ST_ROUND;
                end else begin
                    w_d = {w_q[MAG_W-2:0], 1'b0};
                    e_d = e_q - 3'd1;
                end
            end
            ST_ROUND: begin
                fp_sign_d = s_q;
                fp_exp_d  = rnd_exp;
                fp_sig_d  = rnd_sig;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.fp_sign   = fp_sign_q;
    assign bus.fp_exp    = fp_exp_q;
    assign bus.fp_sig    = fp_sig_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Bench for fp_normalizer: table vectors, random values against a leading-one
// model, back-pressure and mid-operation reset sequences.
module tb_fp_normalizer;
  import fp_normalizer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_normalizer_if bus();

  fp_normalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] mag;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  sg;
    int          lat;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int lat_q[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: locate the leading one directly and round the 4 bits below it.
  function automatic logic [7:0] model(input logic [11:0] mag, input logic s);
    int p;
    logic [11:0] sh;
    logic [4:0] sum;
    logic [2:0] ex;
    if (mag[11]) return {s, 3'd7, 4'hF};
    p = -1;
    for (int i = 0; i < 11; i++) if (mag[i]) p = i;
    if (p < 4) return {s, 3'd0, mag[3:0]};
    ex = 3'(p - 3);
    sh = mag >> (p - 3);
    sum = {1'b0, sh[3:0]} + {4'b0, mag[p-4]};
    if (sum[4]) begin
      if (ex == 3'd7) return {s, 3'd7, 4'hF};
      return {s, ex + 3'd1, 4'h8};
    end
    return {s, ex, sum[3:0]};
  endfunction

  function automatic int model_lat(input logic [11:0] mag);
    int p;
    if (mag[11]) return 3;
    p = -1;
    for (int i = 0; i < 11; i++) if (mag[i]) p = i;
    if (p < 4) return 10;
    return 13 - p;
  endfunction

  task automatic send(input logic [11:0] mag, input logic s);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.magnitude = mag;
    bus.sign = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.magnitude = 12'($urandom);
    bus.sign = 1'($urandom);
  endtask

  // Called right after send: one clock has elapsed since acceptance.
  task automatic collect(input int hold);
    int cyc;
    logic [7:0] exp_v;
    int lat_v;
    cyc = 1;
    while (!bus.out_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    exp_v = exp_q.pop_front();
    lat_v = lat_q.pop_front();
    chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    chk("latency", 32'(cyc), 32'(lat_v));
    chk("result", 32'({bus.fp_sign, bus.fp_exp, bus.fp_sig}), 32'(exp_v));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_result", 32'({bus.out_valid, bus.fp_sign, bus.fp_exp, bus.fp_sig}), 32'({1'b1, exp_v}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("in_ready_after", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_one(input logic [11:0] mag, input logic s, input logic [7:0] ev, input int lat, input int hold);
    exp_q.push_back(ev);
    lat_q.push_back(lat);
    send(mag, s);
    collect(hold);
  endtask

  initial begin
    logic [11:0] m;
    logic s;
    logic [7:0] held;
    int n;

    vecs[0] = '{12'h1A6, 1'b0, 3'd5, 4'b1101, 5};
    vecs[1] = '{12'h07D, 1'b1, 3'd4, 4'b1000, 7};
    vecs[2] = '{12'h800, 1'b1, 3'd7, 4'hF, 3};
    vecs[3] = '{12'h7FF, 1'b0, 3'd7, 4'hF, 3};
    vecs[4] = '{12'h005, 1'b0, 3'd0, 4'b0101, 10};
    vecs[5] = '{12'h000, 1'b1, 3'd0, 4'b0000, 10};
    vecs[6] = '{12'h00F, 1'b0, 3'd0, 4'hF, 10};
    vecs[7] = '{12'h040, 1'b1, 3'd3, 4'b1000, 7};
    vecs[8] = '{12'h7C0, 1'b0, 3'd7, 4'hF, 3};
    vecs[9] = '{12'h3F8, 1'b1, 3'd7, 4'b1000, 4};

    bus.in_valid = 1'b0;
    bus.sign = 1'b0;
    bus.magnitude = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_fp", 32'({bus.fp_sign, bus.fp_exp, bus.fp_sig}), 32'd0);
    chk("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_one(vecs[i].mag, vecs[i].s, {vecs[i].s, vecs[i].e, vecs[i].sg}, vecs[i].lat, i % 3);

    for (int i = 0; i < 40; i++) begin
      m = 12'($urandom_range(0, 2048));
      s = 1'($urandom_range(0, 1));
      run_one(m, s, model(m, s), model_lat(m), $urandom_range(0, 2));
    end

    // Back-pressure: result held, new request ignored, released by out_ready.
    exp_q.push_back({1'b0, 3'd5, 4'b1101});
    lat_q.push_back(5);
    send(12'h1A6, 1'b0);
    n = 1;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", 32'(n), 32'(lat_q.pop_front()));
    held = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.magnitude = 12'h123;
        bus.sign = 1'b1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_stable", 32'({bus.fp_sign, bus.fp_exp, bus.fp_sig}), 32'(held));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("bp_ignored_pulse", 32'(n), 32'd0);

    // Reset while shifting: aborted value is never emitted.
    send(12'h005, 1'b1);
    @(negedge clk);
    chk("abort_in_shift", 32'(bus.dbg_state), 32'(ST_SHIFT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_fp", 32'({bus.fp_sign, bus.fp_exp, bus.fp_sig}), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("abort_no_output", 32'(n), 32'd0);

    run_one(12'h07D, 1'b1, {1'b1, 3'd4, 4'b1000}, 7, 1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
